// File: rtl/regfile_write_queue.sv
// Register-file write front end: a small in-order queue that takes ALU and load
// results, retires one write per clock into the single RF write port, and
// exposes two forwarding lookups over every pending write.

// One forwarding lookup port. It scans the output register (oldest) and then the
// valid queue entries from head to tail. Later matches overwrite earlier ones,
// so the youngest pending write to the address wins.
module rfwq_fwd_lookup #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int IW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic [AW-1:0]                addr,
    input  logic                         out_vld,
    input  logic [AW-1:0]                out_rd,
    input  logic [DW-1:0]                out_data,
    input  logic [DEPTH-1:0][AW-1:0]     q_rd,
    input  logic [DEPTH-1:0][DW-1:0]     q_data,
    input  logic [IW-1:0]                head,
    input  logic [CW-1:0]                cnt,
    output logic                         hit,
    output logic [DW-1:0]                data
);
    // Age-ordered scan; the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (out_vld && out_rd == addr) begin
            hit  = 1'b1;
            data = out_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt && q_rd[IW'(head + IW'(i))] == addr) begin
                hit  = 1'b1;
                data = q_data[IW'(head + IW'(i))];
            end
        end
    end
endmodule

module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [AW-1:0]              mem_rd,
    input  logic [DW-1:0]              mem_data,
    output logic                       mem_ready,
    output logic                       we_RF,
    output logic [AW-1:0]              rd,
    output logic [DW-1:0]              WD3,
    input  logic [AW-1:0]              fwd_addr_a,
    input  logic [AW-1:0]              fwd_addr_b,
    output logic                       fwd_hit_a,
    output logic                       fwd_hit_b,
    output logic [DW-1:0]              fwd_data_a,
    output logic [DW-1:0]              fwd_data_b,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [DEPTH-1:0][AW-1:0]   q_rd;
    logic [DEPTH-1:0][DW-1:0]   q_data;
    logic [PW-1:0]              free;
    logic                       alu_push, mem_push, pop;
    logic [IW-1:0]              alu_idx, mem_idx, head;

    // Occupancy and free space come from registered pointers only, so a pop in
    // this cycle never makes room for a push in the same cycle.
    always_comb begin
        count     = wr_ptr - rd_ptr;
        free      = PW'(DEPTH) - count;
        alu_ready = (free >= PW'(1));
        mem_ready = (free >= PW'(2)) || (free == PW'(1) && !alu_valid);
        alu_push  = alu_valid && alu_ready && !flush;
        mem_push  = mem_valid && mem_ready && !flush;
        pop       = (count != '0) && !flush;
        head      = rd_ptr[IW-1:0];
        alu_idx   = wr_ptr[IW-1:0];
        mem_idx   = wr_ptr[IW-1:0] + IW'(alu_push);
    end

    // Pointer update: flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(alu_push) + PW'(mem_push);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end

    // Queue storage: ALU entry lands first (older), the load entry right behind it.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            q_rd[alu_idx]   <= alu_rd;
            q_data[alu_idx] <= alu_data;
        end
        if (mem_push) begin
            q_rd[mem_idx]   <= mem_rd;
            q_data[mem_idx] <= mem_data;
        end
    end

    // Output register: head pops into the RF write port; rd/WD3 hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_RF <= 1'b0;
            rd    <= '0;
            WD3   <= '0;
        end else if (flush) begin
            we_RF <= 1'b0;
        end else if (pop) begin
            we_RF <= 1'b1;
            rd    <= q_rd[head];
            WD3   <= q_data[head];
        end else begin
            we_RF <= 1'b0;
        end
    end

    logic [1:0][AW-1:0] l_addr;
    logic [1:0]         l_hit;
    logic [1:0][DW-1:0] l_data;

    assign l_addr     = {fwd_addr_b, fwd_addr_a};
    assign fwd_hit_a  = l_hit[0];
    assign fwd_hit_b  = l_hit[1];
    assign fwd_data_a = l_data[0];
    assign fwd_data_b = l_data[1];

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        rfwq_fwd_lookup #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (DW)
        ) u_fwd (
            .addr     (l_addr[g]),
            .out_vld  (we_RF),
            .out_rd   (rd),
            .out_data (WD3),
            .q_rd     (q_rd),
            .q_data   (q_data),
            .head     (head),
            .cnt      (count),
            .hit      (l_hit[g]),
            .data     (l_data[g])
        );
    end
endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side front end for the processor's register file. Accepts results from the ALU and the load path, buffers them in a small in-order queue, and retires at most one write per clock into the register file's single write port (`we_RF`, `rd`, `WD3`). Provides two combinational forwarding lookup ports so the decode stage sees values that are queued but not yet written.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- AW, 4, register address width (16 registers)
- DW, 32, data width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset
- flush  in  1  discard all queued and pending writes
- alu_valid  in  1  ALU result offered
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU result accepted this cycle if alu_valid
- mem_valid  in  1  load result offered
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load result accepted this cycle if mem_valid
- we_RF  out  1  register file write enable (registered)
- rd  out  AW  register file write address (registered)
- WD3  out  DW  register file write data (registered)
- fwd_addr_a, fwd_addr_b  in  AW  lookup addresses
- fwd_hit_a, fwd_hit_b  out  1  pending write to that address exists
- fwd_data_a, fwd_data_b  out  DW  youngest pending data for that address
- count  out  $clog2(DEPTH)+1  current queue occupancy (excludes output register)

## Operation
- Queue: circular buffer, wr_ptr/rd_ptr with one extra wrap bit; count = wr_ptr − rd_ptr.
- free = DEPTH − count, computed from registered state only (a drain in the same cycle does not create space).
- alu_ready = (free ≥ 1). mem_ready = (free ≥ 2) or (free == 1 and !alu_valid).
- Same-cycle enqueue order: ALU entry first (older), then load entry.
- Drain: every edge where count > 0 and !flush, the head pops into the output register; we_RF←1, rd/WD3←head. When count == 0, we_RF←0; rd/WD3 hold their previous values.
- Push and pop in the same edge are allowed; count updates by (pushes − pop).
- flush (priority over everything): rd_ptr←wr_ptr←0, we_RF←0; inputs presented in the flush cycle are not accepted (alu_ready/mem_ready still reflect pre-flush state but acceptance is ignored).
- Forwarding: candidates are the output register (when we_RF=1, oldest) and all valid queue entries in age order; the youngest match wins. No match: hit=0, data=0. Both ports independent and purely combinational from registered state; they do not see same-cycle input offers.
- Duplicate destinations are legal; all writes are issued in order.
- No address is filtered; register 0 is written like any other.

## Timing
- Reset values: we_RF=0, rd=0, WD3=0, count=0, pointers=0, alu_ready=1, mem_ready=1, fwd_hit_*=0, fwd_data_*=0.
- Latency: result accepted at edge E enters queue; if it is the head, it reaches the output register at edge E+1; we_RF high for the cycle after E+1 (2 cycles from offer cycle to write cycle).
- Throughput: one write per cycle sustained; two pushes per cycle only when free ≥ 2.
- Full (count == DEPTH): both readies low; drain continues; readies return the cycle after a pop.
- Empty: we_RF deasserts one cycle after the last entry issues.
- Reset mid-operation: all queued writes discarded, we_RF=0 the cycle after the reset edge.

## Test plan
- Reset: assert rst 2 cycles with alu_valid=1 → we_RF=0, count=0, both readies 1 after release; no write issued.
- Single ALU write: alu_rd=3, alu_data=0x0000_00AA offered one cycle → we_RF=1, rd=3, WD3=0xAA exactly 2 cycles later, for one cycle; fwd_addr_a=3 hits with 0xAA from cycle after acceptance until we_RF drops.
- Dual push ordering: same cycle alu(rd=5, 0x11) and mem(rd=5, 0x22) → writes in order 0x11 then 0x22 on consecutive cycles; fwd on 5 returns 0x22 while both pending, 0x22 when only the later remains.
- Full/backpressure: hold alu_valid and mem_valid continuously with DEPTH=4 → count never exceeds 4, mem_ready=0 whenever free<2 and alu_valid=1, every accepted value written exactly once in order, none lost.
- Flush: queue holding 3 entries, assert flush one cycle → count=0 and we_RF=0 the next cycle; no flushed value appears on WD3; fwd_hit_*=0.
- Simultaneous push/pop at count=1: push one ALU entry while head drains → count stays 1, we_RF=1 continuously.
